// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter slice.
package mem_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_M, OWN_D} arb_owner_t;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

endpackage

// File: rtl/dm_starve_ctr.sv
// Saturating count of D denials; once at the limit, D takes the next arbitration.
module dm_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A limit of zero disables forced D priority entirely.
  assign at_limit = (LIMIT != 0) && (cnt_q == W'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the MEM stage (M) and a
// secondary D port, covering multi-cycle DM latency and D starvation.
module dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_re,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d, cur_owner;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              m_act, grant_m, grant_d, completing, cur_we;
  logic              d_at_limit, starve_inc;

  assign m_act = m_re | m_we;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    cur_owner  = OWN_NONE;
    cur_we     = 1'b0;
    completing = 1'b0;
    grant_m    = 1'b0;
    grant_d    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    m_rdata    = '0;
    d_rdata    = '0;
    d_gnt      = 1'b0;
    d_valid    = 1'b0;

    // While reset is held nothing is granted and no strobe reaches DM.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          grant_m = m_act && !(d_req && d_at_limit);
          grant_d = d_req && !grant_m;
          if (grant_m) begin
            cur_owner = OWN_M;
            cur_we    = m_we;
            mem_addr  = m_addr;
            mem_wdata = m_wdata;
          end else if (grant_d) begin
            cur_owner = OWN_D;
            cur_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            d_gnt     = 1'b1;
          end
          if (grant_m || grant_d) begin
            mem_we  = cur_we;
            mem_re  = !cur_we;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            we_d    = cur_we;
            if (LATENCY == 1) begin
              completing = 1'b1;
            end else begin
              state_d = BUSY;
              owner_d = cur_owner;
              cnt_d   = CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          cur_owner = owner_q;
          cur_we    = we_q;
          mem_we    = we_q;
          mem_re    = !we_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            completing = 1'b1;
            state_d    = IDLE;
            owner_d    = OWN_NONE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (completing && (cur_owner == OWN_M) && !cur_we) begin
        m_rdata = mem_rdata;
      end
      if (completing && (cur_owner == OWN_D)) begin
        d_valid = 1'b1;
        if (!cur_we) begin
          d_rdata = mem_rdata;
        end
      end
    end

    m_stall = m_act && !((cur_owner == OWN_M) && completing);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign starve_inc = (state_q == IDLE) && d_req && grant_m;

  dm_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (starve_inc),
    .clr     (grant_d),
    .at_limit(d_at_limit)
  );

  // The MEM stage must never issue read and write together; write wins if it does.
  a_m_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(m_re && m_we));

endmodule
